// File: rtl/dpa_pkg.sv
// Shared definitions for the digital photo album copy datapath.
// Holds the copy-engine state encoding, default widths and the
// active-low write-enable levels used on the image memory port.
package dpa_pkg;

  localparam int AW_DEF          = 20;
  localparam int DW_DEF          = 24;
  localparam int FB_DIM_LOG2_DEF = 7;
  localparam int MAX_PHASES_DEF  = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD      = 2'd1,
    WR      = 2'd2,
    PH_WAIT = 2'd3
  } state_e;

  localparam logic WEN_WRITE = 1'b0;
  localparam logic WEN_READ  = 1'b1;

endpackage

// File: rtl/dpa_copy_addr_gen.sv
// Phase/row/column walker and address generator for the copy engine.
// Ports:
//   clk, reset        clock, async active-high reset
//   load              latch copy configuration and restart at p=0,r=0,c=0
//   src_base, fb_base source / frame-buffer base addresses (sampled on load)
//   src_dbl           source is 2x size, take even rows/cols (sampled on load)
//   num_phases        requested phase count, clamped to 1..MAX_PHASES on load
//   step              advance to the next pixel of the current phase
//   next_phase        move to the first pixel of the next phase
//   src_addr/dst_addr addresses of the current pixel
//   last_of_phase     current pixel is the last one of its phase
//   last_phase        current phase is the final phase
module dpa_copy_addr_gen
  import dpa_pkg::*;
#(
  parameter int AW          = AW_DEF,
  parameter int FB_DIM_LOG2 = FB_DIM_LOG2_DEF,
  parameter int MAX_PHASES  = MAX_PHASES_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load,
  input  logic [AW-1:0]                src_base,
  input  logic [AW-1:0]                fb_base,
  input  logic                         src_dbl,
  input  logic [$clog2(MAX_PHASES):0]  num_phases,
  input  logic                         step,
  input  logic                         next_phase,
  output logic [AW-1:0]                src_addr,
  output logic [AW-1:0]                dst_addr,
  output logic                         last_of_phase,
  output logic                         last_phase
);

  localparam int PW = $clog2(MAX_PHASES) + 1;
  localparam int SW = FB_DIM_LOG2 + PW;
  localparam int D  = 1 << FB_DIM_LOG2;

  logic [AW-1:0]          src_base_q, fb_base_q;
  logic                   dbl_q;
  logic [PW-1:0]          n_q, p_q, n_eff, p_inc;
  logic [FB_DIM_LOG2-1:0] row_q, col_q;
  logic [SW-1:0]          row_sum;
  logic [AW-1:0]          off_nat, off_dbl;

  always_comb begin
    n_eff = num_phases;
    if (num_phases == '0)
      n_eff = PW'(1);
    else if (num_phases > PW'(MAX_PHASES))
      n_eff = PW'(MAX_PHASES);
  end

  assign p_inc   = p_q + 1'b1;
  // rows of a phase are p, p+N, p+2N...; the sum is kept wide so the
  // end-of-phase test sees the overflow past the last row
  assign row_sum = SW'(row_q) + SW'(n_q);

  assign last_of_phase = (&col_q) && (row_sum >= SW'(D));
  assign last_phase    = (p_inc == n_q);

  // r*D + c is a plain concatenation; the decimated source skips every
  // other column and every other row of a 2D-wide image: (2r)(2D) + 2c
  assign off_nat  = AW'({row_q, col_q});
  assign off_dbl  = AW'({row_q, 1'b0, col_q, 1'b0});
  assign src_addr = src_base_q + (dbl_q ? off_dbl : off_nat);
  assign dst_addr = fb_base_q + off_nat;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_base_q <= '0;
      fb_base_q  <= '0;
      dbl_q      <= 1'b0;
      n_q        <= PW'(1);
      p_q        <= '0;
      row_q      <= '0;
      col_q      <= '0;
    end else if (load) begin
      src_base_q <= src_base;
      fb_base_q  <= fb_base;
      dbl_q      <= src_dbl;
      n_q        <= n_eff;
      p_q        <= '0;
      row_q      <= '0;
      col_q      <= '0;
    end else if (next_phase) begin
      p_q   <= p_inc;
      row_q <= FB_DIM_LOG2'(p_inc);
      col_q <= '0;
    end else if (step) begin
      if (&col_q) begin
        col_q <= '0;
        row_q <= FB_DIM_LOG2'(row_sum);
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/dpa_fb_copy_engine.sv
// Photo-to-frame-buffer copy engine. Copies one FB_DIM x FB_DIM picture
// (optionally 2:1 decimated from a 2*FB_DIM source) over a shared
// single-port image memory, as a multi-phase interleaved row transition.
// Ports:
//   clk, reset           clock, async active-high reset
//   start, abort         launch (ignored while busy) / synchronous cancel
//   src_base, src_dbl,
//   fb_base, num_phases  copy configuration, sampled at start
//   phase_go             releases the next phase (sticky while busy)
//   mem_gnt              engine owns the memory this cycle
//   mem_a, mem_d,
//   mem_wen, mem_q       memory port, mem_wen active low, mem_q one cycle late
//   busy, phase_done,
//   done                 status and completion pulses
module dpa_fb_copy_engine
  import dpa_pkg::*;
#(
  parameter int AW          = AW_DEF,
  parameter int DW          = DW_DEF,
  parameter int FB_DIM_LOG2 = FB_DIM_LOG2_DEF,
  parameter int MAX_PHASES  = MAX_PHASES_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         abort,
  input  logic [AW-1:0]                src_base,
  input  logic                         src_dbl,
  input  logic [AW-1:0]                fb_base,
  input  logic [$clog2(MAX_PHASES):0]  num_phases,
  input  logic                         phase_go,
  input  logic                         mem_gnt,
  output logic [AW-1:0]                mem_a,
  output logic [DW-1:0]                mem_d,
  output logic                         mem_wen,
  input  logic [DW-1:0]                mem_q,
  output logic                         busy,
  output logic                         phase_done,
  output logic                         done
);

  localparam logic [1:0] ST_IDLE    = IDLE;
  localparam logic [1:0] ST_RD      = RD;
  localparam logic [1:0] ST_WR      = WR;
  localparam logic [1:0] ST_PH_WAIT = PH_WAIT;

  logic [1:0]    state;
  logic          go_pend, wr_first;
  logic [DW-1:0] pix_hold;
  logic [AW-1:0] src_addr, dst_addr;
  logic          last_of_phase, last_phase;
  logic          load, step, next_phase;

  assign load       = (state == ST_IDLE) && start && !abort;
  assign step       = (state == ST_WR) && mem_gnt;
  assign next_phase = (state == ST_PH_WAIT) && go_pend && !abort;
  assign busy       = (state != ST_IDLE);

  dpa_copy_addr_gen #(
    .AW          (AW),
    .FB_DIM_LOG2 (FB_DIM_LOG2),
    .MAX_PHASES  (MAX_PHASES)
  ) u_addr_gen (
    .clk           (clk),
    .reset         (reset),
    .load          (load),
    .src_base      (src_base),
    .fb_base       (fb_base),
    .src_dbl       (src_dbl),
    .num_phases    (num_phases),
    .step          (step),
    .next_phase    (next_phase),
    .src_addr      (src_addr),
    .dst_addr      (dst_addr),
    .last_of_phase (last_of_phase),
    .last_phase    (last_phase)
  );

  // mem_q is only valid in the first WR cycle; a grant stall replays the
  // held copy so the written pixel never picks up unrelated read data
  always_comb begin
    mem_a   = '0;
    mem_d   = '0;
    mem_wen = WEN_READ;
    case (state)
      ST_RD: mem_a = src_addr;
      ST_WR: begin
        mem_a = dst_addr;
        mem_d = wr_first ? mem_q : pix_hold;
        if (mem_gnt)
          mem_wen = WEN_WRITE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      go_pend    <= 1'b0;
      wr_first   <= 1'b0;
      pix_hold   <= '0;
      phase_done <= 1'b0;
      done       <= 1'b0;
    end else begin
      phase_done <= 1'b0;
      done       <= 1'b0;
      if (abort) begin
        state    <= ST_IDLE;
        wr_first <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              state   <= ST_RD;
              go_pend <= 1'b0;
            end
          end
          ST_RD: begin
            if (mem_gnt) begin
              state    <= ST_WR;
              wr_first <= 1'b1;
            end
          end
          ST_WR: begin
            wr_first <= 1'b0;
            if (wr_first)
              pix_hold <= mem_q;
            if (mem_gnt) begin
              if (last_of_phase) begin
                phase_done <= 1'b1;
                if (last_phase) begin
                  done  <= 1'b1;
                  state <= ST_IDLE;
                end else begin
                  state <= ST_PH_WAIT;
                end
              end else begin
                state <= ST_RD;
              end
            end
          end
          default: begin
            if (go_pend) begin
              go_pend <= 1'b0;
              state   <= ST_RD;
            end
          end
        endcase
      end
      // a go that lands mid-phase stays pending until the phase ends
      if (phase_go && state != ST_IDLE)
        go_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dpa_fb_copy_engine.sv
// Directed bench for dpa_fb_copy_engine: a memory model returning an
// address-derived pixel, a write monitor holding a reference walk of the
// expected copy order, and a linear sequence of directed steps.
module tb_dpa_fb_copy_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, abort = 1'b0, src_dbl = 1'b0, phase_go = 1'b0;
  logic        mem_gnt = 1'b1;
  logic [19:0] src_base = '0, fb_base = '0;
  logic [2:0]  num_phases = 3'd1;
  logic [23:0] mem_q = '0;
  logic [19:0] mem_a;
  logic [23:0] mem_d;
  logic        mem_wen, busy, phase_done, done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dpa_fb_copy_engine #(
    .AW (20), .DW (24), .FB_DIM_LOG2 (7), .MAX_PHASES (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .src_base   (src_base),
    .src_dbl    (src_dbl),
    .fb_base    (fb_base),
    .num_phases (num_phases),
    .phase_go   (phase_go),
    .mem_gnt    (mem_gnt),
    .mem_a      (mem_a),
    .mem_d      (mem_d),
    .mem_wen    (mem_wen),
    .mem_q      (mem_q),
    .busy       (busy),
    .phase_done (phase_done),
    .done       (done)
  );

  function automatic logic [23:0] pix(input logic [19:0] a);
    return {4'h5, a ^ 20'h3C3C3};
  endfunction

  always @(posedge clk) mem_q <= pix(mem_a);

  // monitor state
  int cyc = 0, wr_count = 0, wr_bad = 0, bad_wen = 0;
  int pd_count = 0, pd_bad = 0, done_count = 0, done_cyc = 0, start_cyc = 0;
  int pe_cyc = -10, prev_wr_cyc = 0, ph_gap = 0, ph_stalls = 0;
  int exp_p = 0, exp_r = 0, exp_c = 0, m_n = 1;
  logic        m_dbl = 1'b0;
  logic [19:0] m_src = '0, m_fb = '0, e_src = '0, e_dst = '0;
  logic [19:0] last_addr = '0, first_addr = '0;
  logic [23:0] last_data = '0, d_fb1 = '0, d_fb128 = '0;

  initial begin : monitor
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        if (start && !busy && !abort) begin
          m_src = src_base; m_fb = fb_base; m_dbl = src_dbl;
          m_n = num_phases;
          if (m_n == 0) m_n = 1;
          if (m_n > 4) m_n = 4;
          exp_p = 0; exp_r = 0; exp_c = 0;
          wr_count = 0; wr_bad = 0; bad_wen = 0; pd_count = 0; pd_bad = 0;
          done_count = 0; ph_gap = 0; ph_stalls = 0; pe_cyc = -10;
          start_cyc = cyc; first_addr = '0;
        end
        if (mem_wen == 1'b0) begin
          if (!mem_gnt) bad_wen++;
          e_dst = m_fb + 20'(exp_r * 128 + exp_c);
          e_src = m_dbl ? m_src + 20'(exp_r * 512 + exp_c * 2)
                        : m_src + 20'(exp_r * 128 + exp_c);
          if (mem_a !== e_dst || mem_d !== pix(e_src)) wr_bad++;
          if (wr_count == 0) first_addr = mem_a;
          if (mem_a == m_fb + 20'd1)   d_fb1 = mem_d;
          if (mem_a == m_fb + 20'd128) d_fb128 = mem_d;
          if (exp_c == 0 && exp_r == exp_p && exp_p > 0) begin
            ph_gap = cyc - prev_wr_cyc;
            if (ph_gap > 2) ph_stalls++;
          end
          prev_wr_cyc = cyc;
          wr_count++;
          last_addr = mem_a;
          last_data = mem_d;
          exp_c++;
          if (exp_c == 128) begin
            exp_c = 0;
            exp_r += m_n;
            if (exp_r >= 128) begin
              pe_cyc = cyc;
              exp_p++;
              exp_r = exp_p;
            end
          end
        end
        if (phase_done) begin
          pd_count++;
          if (cyc != pe_cyc + 1) pd_bad++;
        end
        if (done) begin
          done_count++;
          done_cyc = cyc;
          if (!phase_done || busy) pd_bad++;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic pulse_go;
    @(posedge clk); #1 phase_go = 1'b1;
    @(posedge clk); #1 phase_go = 1'b0;
  endtask

  task automatic wait_wr(input int n, input int budget, input string tag);
    for (int i = 0; i < budget && wr_count < n; i++) tick;
    chk({tag, "_wr_reached"}, 32'(wr_count >= n), 32'd1);
  endtask

  task automatic wait_pd(input int n, input int budget, input string tag);
    for (int i = 0; i < budget && pd_count < n; i++) tick;
    chk({tag, "_pd_reached"}, 32'(pd_count >= n), 32'd1);
  endtask

  task automatic wait_done(input int budget, input string tag);
    for (int i = 0; i < budget && done_count == 0; i++) tick;
    chk({tag, "_done_reached"}, 32'(done_count), 32'd1);
  endtask

  logic [19:0] a_tmp;

  initial begin
    // reset state
    #12;
    chk("rst_mem_a", mem_a, 0);
    chk("rst_mem_d", mem_d, 0);
    chk("rst_mem_wen", mem_wen, 1);
    chk("rst_busy", busy, 0);
    chk("rst_phase_done", phase_done, 0);
    chk("rst_done", done, 0);
    @(posedge clk); #1 reset = 1'b0;

    // native copy, one phase
    src_base = 20'h00100; fb_base = 20'h80000; src_dbl = 1'b0; num_phases = 3'd1;
    pulse_start;
    wait_done(40000, "nat");
    chk("nat_writes", wr_count, 16384);
    chk("nat_wr_bad", wr_bad, 0);
    chk("nat_last_addr", last_addr, 20'h83FFF);
    a_tmp = 20'h040FF;
    chk("nat_last_data", last_data, pix(a_tmp));
    chk("nat_latency", done_cyc - start_cyc - 1, 32768);
    chk("nat_pd_count", pd_count, 1);
    chk("nat_pd_align", pd_bad, 0);
    tick;
    chk("nat_busy_after", busy, 0);

    // decimated four-phase transition with a grant stall; inputs are
    // scrambled right after start to show they were latched
    src_base = 20'h10000; fb_base = 20'h80000; src_dbl = 1'b1; num_phases = 3'd4;
    pulse_start;
    src_base = 20'hFFFFF; fb_base = 20'h00000; src_dbl = 1'b0; num_phases = 3'd1;
    wait_wr(5, 100, "dec");
    for (int i = 0; i < 4 && mem_wen !== 1'b0; i++) tick;
    @(posedge clk);
    @(posedge clk); #1 mem_gnt = 1'b0;
    repeat (5) @(posedge clk);
    #1 mem_gnt = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      wait_pd(k, 20000, "dec");
      repeat (10) @(posedge clk);
      #1 phase_go = 1'b1;
      @(posedge clk); #1 phase_go = 1'b0;
    end
    wait_done(20000, "dec");
    chk("dec_writes", wr_count, 16384);
    chk("dec_wr_bad", wr_bad, 0);
    chk("dec_wen_no_gnt", bad_wen, 0);
    a_tmp = 20'h10002;
    chk("dec_fb1_data", d_fb1, pix(a_tmp));
    a_tmp = 20'h10200;
    chk("dec_fb128_data", d_fb128, pix(a_tmp));
    chk("dec_pd_count", pd_count, 4);
    chk("dec_ph_stalls", ph_stalls, 3);
    chk("dec_pd_align", pd_bad, 0);

    // early go: released mid-phase 0, phase 1 follows with one PH_WAIT cycle
    src_base = 20'h00100; fb_base = 20'h80000; src_dbl = 1'b0; num_phases = 3'd2;
    pulse_start;
    wait_wr(100, 1000, "eg");
    pulse_go;
    wait_pd(1, 20000, "eg");
    wait_wr(8202, 100, "eg1");
    chk("eg_gap", ph_gap, 3);
    chk("eg_wr_bad", wr_bad, 0);
    chk("eg_pd_count", pd_count, 1);
    chk("eg_no_done", done_count, 0);
    chk("eg_busy", busy, 1);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    tick;
    chk("eg_abort_busy", busy, 0);

    // abort during the WR cycle of pixel 1000 (num_phases=0 runs as 1)
    num_phases = 3'd0;
    pulse_start;
    wait_wr(999, 3000, "ab");
    @(posedge clk);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    chk("ab_busy", busy, 0);
    chk("ab_wen", mem_wen, 1);
    repeat (20) tick;
    chk("ab_writes", wr_count, 1000);
    chk("ab_no_done", done_count, 0);
    chk("ab_no_pd", pd_count, 0);
    chk("ab_wr_bad", wr_bad, 0);

    // restart from row 0; num_phases=7 clamps to 4 so write 129 lands on row 4
    num_phases = 3'd7;
    pulse_start;
    wait_wr(130, 400, "rs");
    chk("rs_first_addr", first_addr, 20'h80000);
    chk("rs_wr_bad", wr_bad, 0);
    chk("rs_last_addr", last_addr, 20'h80201);

    // async reset in the middle of a WR cycle
    for (int i = 0; i < 4 && mem_wen !== 1'b0; i++) tick;
    chk("ar_in_write", mem_wen, 0);
    #1 reset = 1'b1;
    #1;
    chk("ar_mem_a", mem_a, 0);
    chk("ar_mem_d", mem_d, 0);
    chk("ar_mem_wen", mem_wen, 1);
    chk("ar_busy", busy, 0);
    chk("ar_phase_done", phase_done, 0);
    chk("ar_done", done, 0);
    @(posedge clk); #1 reset = 1'b0;
    tick;
    chk("ar_idle_after", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
